// File: rtl/lpf_cfg_if.sv
// Register bus between a configuration master and the low-pass-filter config controller.
// Write path is flow-controlled by wr_ready; reads always complete one cycle after rd_en.
interface lpf_cfg_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/lpf_cfg_ctrl.sv
// Threshold configuration controller for NCH low-pass filter channels: shadow/active registers,
// a commit FSM that waits for each channel to go quiescent before applying and flushing it.
module lpf_cfg_ctrl #(
    parameter int NCH = 4,
    parameter int TW  = 14
) (
    input  logic              clk,
    input  logic              reset,
    lpf_cfg_if.slave          bus,
    input  logic [NCH-1:0]    sig_raw,
    input  logic [NCH-1:0]    sig_filt,
    output logic [NCH*TW-1:0] lpf_threshold,
    output logic [NCH-1:0]    lpf_reset,
    output logic              busy
);

    localparam int         CW          = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0] ADDR_MASK   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;
    localparam logic [3:0] ADDR_CNT    = 4'd10;
    localparam logic [9:0] WAIT_LAST   = 10'd1023;

    typedef enum logic [2:0] {IDLE, SELECT, WAIT_STABLE, APPLY, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   shadow_q [NCH];
    logic [TW-1:0]   active_q [NCH];
    logic [15:0]     cnt_q    [NCH];
    logic [NCH-1:0]  mask_q;
    logic [NCH-1:0]  filt_q;
    logic [NCH-1:0]  filt_chg;
    logic [CW-1:0]   chan_q;
    logic [CW-1:0]   low_idx;
    logic [CW-1:0]   rd_cidx;
    logic [1:0]      stab_q;
    logic [9:0]      wait_q;
    logic            flush_q;
    logic            timeout_q;
    logic            idle, wr_ok, commit_go;
    logic            chan_eq, stable_done, timed_out;
    logic            cnt_addr_hit, rd_cnt_hit;
    logic [15:0]     rd_mux;
    logic            unused_wr_bits;

    assign idle         = (state_q == IDLE);
    assign bus.wr_ready = idle;
    assign busy         = ~idle;
    assign wr_ok        = bus.wr_en && idle;
    assign commit_go    = wr_ok && (bus.wr_addr == ADDR_MASK) && (bus.wr_data[NCH-1:0] != '0);

    assign chan_eq      = (sig_raw[chan_q] == sig_filt[chan_q]);
    assign stable_done  = chan_eq && (stab_q == 2'd3);
    assign timed_out    = (wait_q == WAIT_LAST) && !stable_done;

    assign filt_chg     = (sig_filt ^ filt_q) & ~lpf_reset;
    assign cnt_addr_hit = (bus.rd_addr >= ADDR_CNT) && ({1'b0, bus.rd_addr} < 5'(10 + NCH));
    assign rd_cnt_hit   = bus.rd_en && cnt_addr_hit;
    assign rd_cidx      = CW'(bus.rd_addr - ADDR_CNT);

    // Upper write-data bits beyond TW/NCH carry no state.
    assign unused_wr_bits = ^bus.wr_data;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        low_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = CW'(i);
        end
    end

    always_comb begin
        lpf_threshold = '0;
        for (int c = 0; c < NCH; c++) lpf_threshold[c*TW +: TW] = active_q[c];
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (commit_go) state_d = SELECT;
            SELECT:      state_d = (mask_q == '0) ? IDLE : WAIT_STABLE;
            WAIT_STABLE: if (stable_done || timed_out) state_d = APPLY;
            APPLY:       state_d = FLUSH;
            FLUSH:       if (flush_q) state_d = SELECT;
            default:     state_d = IDLE;
        endcase
    end

    // NOTE: the small shadow/active arrays are reset explicitly because zero is a defined bypass value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
            end
            mask_q    <= '0;
            chan_q    <= '0;
            stab_q    <= '0;
            wait_q    <= '0;
            flush_q   <= 1'b0;
            timeout_q <= 1'b0;
            lpf_reset <= '1;
        end else begin
            lpf_reset <= (state_d == FLUSH) ? (NCH'(1) << chan_q) : '0;
            if (wr_ok && (bus.wr_addr < 4'(NCH)))
                shadow_q[bus.wr_addr[CW-1:0]] <= bus.wr_data[TW-1:0];
            if (commit_go) begin
                mask_q    <= bus.wr_data[NCH-1:0];
                timeout_q <= 1'b0;
            end
            case (state_q)
                SELECT: if (mask_q != '0) begin
                    chan_q          <= low_idx;
                    mask_q[low_idx] <= 1'b0;
                    stab_q          <= '0;
                    wait_q          <= '0;
                end
                WAIT_STABLE: begin
                    stab_q <= chan_eq ? stab_q + 2'd1 : 2'd0;
                    wait_q <= wait_q + 10'd1;
                    if (timed_out) timeout_q <= 1'b1;
                end
                APPLY: begin
                    active_q[chan_q] <= shadow_q[chan_q];
                    flush_q          <= 1'b0;
                end
                FLUSH:   flush_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Previous filter output for edge detection; value during reset is irrelevant since
    // lpf_reset masks counting in the first cycle afterwards.
    always_ff @(posedge clk) filt_q <= sig_filt;

    // A read clears the counter but keeps an increment that lands in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (rd_cnt_hit && (rd_cidx == CW'(c)))
                    cnt_q[c] <= {15'd0, filt_chg[c]};
                else if (filt_chg[c] && (cnt_q[c] != 16'hFFFF))
                    cnt_q[c] <= cnt_q[c] + 16'd1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (bus.rd_addr < 4'(NCH))
            rd_mux[TW-1:0] = shadow_q[bus.rd_addr[CW-1:0]];
        else if (bus.rd_addr == ADDR_STATUS)
            rd_mux = {4'd0, 4'(chan_q), 6'd0, timeout_q, busy};
        else if (cnt_addr_hit)
            rd_mux = cnt_q[rd_cidx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            bus.rd_data  <= bus.rd_en ? rd_mux : 16'd0;
        end
    end

endmodule
